// File: rtl/frame_write_packer.sv
// Packs a raster pixel stream into memory words and issues single-cycle writes to the frame memory.
// Tracks frame boundaries, reports a premature start-of-frame and pulses frame_done on the last word.
module frame_write_packer #(
    parameter int DATA_WIDTH   = 96,
    parameter int PIX_WIDTH    = 24,
    parameter int PIX_PER_WORD = DATA_WIDTH / PIX_WIDTH,
    parameter int H_ACTIVE     = 320,
    parameter int V_ACTIVE     = 240,
    parameter int ADDR_DEPTH   = 512 * 512 / 4,
    parameter int ADDR_WIDTH   = $clog2(ADDR_DEPTH),
    parameter int FRAME_WORDS  = H_ACTIVE * V_ACTIVE / PIX_PER_WORD
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  pix_vld,
    input  logic                  pix_sof,
    input  logic [PIX_WIDTH-1:0]  pix_data,
    output logic                  pix_rdy,
    output logic                  csn,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  frame_done,
    output logic                  sof_err
);

    localparam int SLOT_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int CNT_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state;
    logic [SLOT_W-1:0]     slot;
    logic [CNT_W-1:0]      word_cnt;
    logic [ADDR_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] pack;
    logic [DATA_WIDTH-1:0] packed_word;
    logic [SLOT_W-1:0]     wr_slot;
    logic                  accept;
    logic                  last_slot;
    logic                  last_word;

    assign accept    = pix_vld & pix_rdy;
    assign last_slot = (slot == SLOT_W'(PIX_PER_WORD - 1));
    assign last_word = (word_cnt == CNT_W'(FRAME_WORDS - 1));
    // A frame (re)start always lands in slot 0, whatever the current slot is.
    assign wr_slot   = (pix_sof || state == IDLE) ? '0 : slot;

    always_comb begin
        packed_word = pack;
        packed_word[int'(wr_slot) * PIX_WIDTH +: PIX_WIDTH] = pix_data;
    end

    // Stale pixels from an aborted word are overwritten before the word is ever written out.
    always_ff @(posedge clk) begin
        if (accept) pack <= packed_word;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            slot       <= '0;
            word_cnt   <= '0;
            base       <= '0;
            pix_rdy    <= 1'b0;
            csn        <= 1'b1;
            wen        <= 1'b1;
            addr       <= '0;
            din        <= '0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            pix_rdy    <= 1'b1;
            csn        <= 1'b1;
            wen        <= 1'b1;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && pix_sof && en) begin
                        state    <= ACTIVE;
                        base     <= base_addr;
                        slot     <= SLOT_W'(1);
                        word_cnt <= '0;
                    end
                end
                ACTIVE: begin
                    if (accept) begin
                        if (pix_sof) begin
                            sof_err  <= 1'b1;
                            word_cnt <= '0;
                            if (en) begin
                                base <= base_addr;
                                slot <= SLOT_W'(1);
                            end else begin
                                state <= IDLE;
                                slot  <= '0;
                            end
                        end else if (last_slot) begin
                            csn  <= 1'b0;
                            wen  <= 1'b0;
                            addr <= base + ADDR_WIDTH'(word_cnt);
                            din  <= packed_word;
                            slot <= '0;
                            if (last_word) begin
                                frame_done <= 1'b1;
                                state      <= IDLE;
                                word_cnt   <= '0;
                            end else begin
                                word_cnt <= word_cnt + CNT_W'(1);
                            end
                        end else begin
                            slot <= slot + SLOT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_write_packer.sv
// Scoreboard bench for frame_write_packer with an 8x2 frame (4 words per frame).
// Stimulus pushes expected writes; a negedge monitor pops and compares each memory write.
module tb_frame_write_packer;

    localparam int DW = 96;
    localparam int PW = 24;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          en = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          pix_vld = 1'b0;
    logic          pix_sof = 1'b0;
    logic [PW-1:0] pix_data = '0;
    logic          pix_rdy, csn, wen, frame_done, sof_err;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;

    frame_write_packer #(
        .DATA_WIDTH(DW), .PIX_WIDTH(PW), .H_ACTIVE(8), .V_ACTIVE(2)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en), .base_addr(base_addr),
        .pix_vld(pix_vld), .pix_sof(pix_sof), .pix_data(pix_data),
        .pix_rdy(pix_rdy), .csn(csn), .wen(wen), .addr(addr), .din(din),
        .frame_done(frame_done), .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          done;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write the DUT presents is matched against the scoreboard head.
    always @(negedge clk) begin
        if (rstn && !csn) begin
            chk("wen_with_csn", DW'(wen), DW'(0));
            if (q.size() == 0) begin
                chk("unexpected_write", DW'(1), DW'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("addr", DW'(addr), DW'(e.a));
                chk("din", din, e.d);
                chk("frame_done", DW'(frame_done), DW'(e.done));
                chk("write_cycle", DW'(cyc), DW'(e.cyc));
            end
        end else if (rstn && frame_done) begin
            chk("done_without_write", DW'(1), DW'(0));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_vld = 1'b0;
            pix_sof = 1'b0;
        end
    endtask

    task automatic send(input logic [PW-1:0] d, input logic sof, input int gap);
        int tries;
        if (gap > 0) idle(gap);
        @(negedge clk);
        pix_vld  = 1'b1;
        pix_sof  = sof;
        pix_data = d;
        tries = 0;
        while (!pix_rdy && tries < 10) begin
            @(negedge clk);
            tries++;
        end
        if (!pix_rdy) chk("pix_rdy_timeout", DW'(0), DW'(1));
        @(posedge clk);
        #1 acc_cyc = cyc;
    endtask

    // Sends npix pixels first..first+npix-1 (SOF on the first) and pushes each completed word.
    task automatic run_frame(input logic [AW-1:0] base, input logic [PW-1:0] first,
                             input int npix, input int gapmode);
        logic [DW-1:0] w;
        exp_t e;
        w = '0;
        base_addr = base;
        for (int i = 0; i < npix; i++) begin
            send(first + PW'(i), i == 0, (gapmode != 0) ? ((i * 7) % 3) : 0);
            w[(i % 4) * PW +: PW] = first + PW'(i);
            if (i % 4 == 3) begin
                e.a = base + AW'(i / 4);
                e.d = w;
                e.done = (i == 15);
                e.cyc = acc_cyc;
                q.push_back(e);
            end
        end
    endtask

    task automatic drain(input string name);
        idle(4);
        chk(name, DW'(q.size()), DW'(0));
    endtask

    logic [DW-1:0] s1_din [4];
    exp_t e1;

    initial begin
        s1_din[0] = {24'h000004, 24'h000003, 24'h000002, 24'h000001};
        s1_din[1] = {24'h000008, 24'h000007, 24'h000006, 24'h000005};
        s1_din[2] = {24'h00000c, 24'h00000b, 24'h00000a, 24'h000009};
        s1_din[3] = {24'h000010, 24'h00000f, 24'h00000e, 24'h00000d};

        // Reset values
        #12;
        chk("rst_pix_rdy", DW'(pix_rdy), DW'(0));
        chk("rst_csn", DW'(csn), DW'(1));
        chk("rst_wen", DW'(wen), DW'(1));
        chk("rst_addr", DW'(addr), DW'(0));
        chk("rst_din", din, DW'(0));
        chk("rst_sof_err", DW'(sof_err), DW'(0));
        @(negedge clk);
        rstn = 1'b1;
        idle(2);
        chk("rdy_after_reset", DW'(pix_rdy), DW'(1));

        // Scenario 1: back-to-back frame, literal expected words
        en = 1'b1;
        base_addr = 16'h0010;
        for (int i = 0; i < 16; i++) begin
            send(PW'(i + 1), i == 0, 0);
            if (i % 4 == 3) begin
                e1.a = 16'h0010 + AW'(i / 4);
                e1.d = s1_din[i / 4];
                e1.done = (i == 15);
                e1.cyc = acc_cyc;
                q.push_back(e1);
            end
        end
        drain("s1_writes");

        // Scenario 2: same frame with valid gaps
        run_frame(16'h0010, 24'h000001, 16, 1);
        drain("s2_writes");
        chk("s2_sof_err", DW'(sof_err), DW'(0));

        // Scenario 3: SOF after 6 pixels aborts, new frame at new base
        run_frame(16'h0020, 24'h000100, 6, 0);
        run_frame(16'h0040, 24'h000200, 16, 0);
        drain("s3_writes");
        chk("s3_sof_err", DW'(sof_err), DW'(1));

        // Scenario 4: address wrap
        run_frame(16'hfffe, 24'h000300, 16, 1);
        drain("s4_writes");

        // Scenario 5: SOF with en=0 and stray pixels in IDLE produce no writes
        en = 1'b0;
        for (int i = 0; i < 8; i++) send(PW'(24'h400 + i), i == 0, 0);
        en = 1'b1;
        for (int i = 0; i < 4; i++) send(PW'(24'h500 + i), 1'b0, 0);
        drain("s5_no_writes");
        run_frame(16'h0080, 24'h000600, 16, 0);
        drain("s5_writes");

        // Scenario 6: async reset mid-frame, then clean frame
        run_frame(16'h0090, 24'h000700, 9, 0);
        idle(0);
        #2 rstn = 1'b0;
        #1;
        chk("r6_csn", DW'(csn), DW'(1));
        chk("r6_wen", DW'(wen), DW'(1));
        chk("r6_addr", DW'(addr), DW'(0));
        chk("r6_din", din, DW'(0));
        chk("r6_done", DW'(frame_done), DW'(0));
        chk("r6_sof_err", DW'(sof_err), DW'(0));
        chk("r6_pix_rdy", DW'(pix_rdy), DW'(0));
        pix_vld = 1'b0;
        pix_sof = 1'b0;
        idle(2);
        rstn = 1'b1;
        drain("r6_no_pending");
        run_frame(16'h0100, 24'h000800, 16, 0);
        drain("r6_writes");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
